serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_fa_cell.sv | 20 ++
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : FSM state encoding and default operand width
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
// ============================================================================
// fa_cell : one-bit combinational full adder
// Rev 1.0
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : LSB-first bit-serial adder with fixed WIDTH+1 cycle latency
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cmsb;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  fa_cell u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  // The counter runs 0..WIDTH; the extra SHIFT cycle at WIDTH publishes the result.
  assign w_last = (r_cnt == CW'(WIDTH));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cmsb <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (!w_last) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_acc <= {w_s, r_acc[WIDTH-1:1]};
            r_c   <= w_co;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) r_cmsb <= r_c;
          end else begin
            r_sum  <= r_acc;
            r_cout <= r_c;
            r_ovf  <= r_cmsb ^ r_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : scoreboard bench for serial_adder against arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    #5;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issues one addition; abort_at > 0 asserts rst in that SHIFT cycle instead.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input bit disturb, input int abort_at);
    exp_t       e;
    logic [W:0] t;
    bit         seen;
    seen = 1'b0;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    t = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (ia[W-1] == ib[W-1]) && (t[W-1] != ia[W-1]);
    @(posedge clk);
    #1;
    e.cyc = cyc + W + 1;
    q.push_back(e);
    start = 1'b0;
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum",  sum,  0);
        check("abort_cout", cout, 0);
        check("abort_ovf",  ovf,  0);
        void'(q.pop_back());
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        @(posedge clk);
        #1;
        check("start_during_rst", busy, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        start = 1'b0;
        return;
      end
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      start = disturb ? 1'($urandom) : 1'b0;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (!seen) void'(q.pop_back());
  endtask

  // Monitor: scoreboard compare on done, output stability otherwise.
  initial begin
    exp_t         e;
    logic [W-1:0] hs;
    logic         hc;
    logic         ho;
    hs = '0; hc = 1'b0; ho = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs = '0; hc = 1'b0; ho = 1'b0;
      end else if (done) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("sum",     sum,  e.sum);
          check("cout",    cout, e.cout);
          check("ovf",     ovf,  e.ovf);
          check("latency", cyc,  e.cyc);
          check("busy_in_done", busy, 1);
          hs = e.sum; hc = e.cout; ho = e.ovf;
        end
      end else begin
        check("hold_sum",  sum,  hs);
        check("hold_cout", cout, hc);
        check("hold_ovf",  ovf,  ho);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  0);
    check("rst_cout", cout, 0);
    check("rst_ovf",  ovf,  0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_first_edge_start", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    start = 1'b0;

    issue(8'h35, 8'h4A, 1'b0, 1'b0, 0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    issue(8'h10, 8'h20, 1'b0, 1'b1, 0);
    issue(8'h80, 8'h80, 1'b0, 1'b0, 0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    issue(8'h00, 8'h00, 1'b0, 1'b0, 0);
    issue(8'h55, 8'h66, 1'b1, 1'b0, 4);
    issue(8'h01, 8'h01, 1'b1, 1'b0, 0);
    issue(8'h12, 8'h34, 1'b0, 1'b0, 0);

    for (int n = 0; n < 1000; n++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
